// File: rtl/zynq_reduce_pkg.sv
// Shared types and constants for the PS->PL group reduction engine.
package zynq_reduce_pkg;

  typedef enum logic [1:0] {e_red_add, e_red_xor, e_red_max, e_red_min} red_op_e;

  localparam int red_queue_els_gp = 2;

endpackage

// File: rtl/zynq_reduce_lane.sv
// One reduction lane: combines a group of FIFO heads, buffers results in a
// 2-entry queue and counts results delivered downstream.
module zynq_reduce_lane
  import zynq_reduce_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int group_p      = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [group_p*data_width_p-1:0] in_data_i,
  input  logic [group_p-1:0]              in_v_i,
  output logic [group_p-1:0]              in_yumi_o,
  input  logic [1:0]                      op_i,
  input  logic                            en_i,
  input  logic                            clear_i,
  output logic [data_width_p-1:0]         out_data_o,
  output logic                            out_v_o,
  input  logic                            out_ready_i,
  output logic [data_width_p-1:0]         count_o
);

  function automatic logic [data_width_p-1:0] reduce_f(
    input logic [group_p*data_width_p-1:0] d,
    input red_op_e                         op
  );
    logic [data_width_p-1:0] acc;
    logic [data_width_p-1:0] x;
    acc = d[data_width_p-1:0];
    for (int i = 1; i < group_p; i++) begin
      x = d[i*data_width_p +: data_width_p];
      case (op)
        e_red_add: acc = acc + x;
        e_red_xor: acc = acc ^ x;
        e_red_max: acc = (x > acc) ? x : acc;
        e_red_min: acc = (x < acc) ? x : acc;
      endcase
    end
    return acc;
  endfunction

  logic [data_width_p-1:0] mem_q [red_queue_els_gp];
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [data_width_p-1:0] count_q, count_d;
  logic                    full, accept, deq;

  // Full comes from the registered occupancy, so a dequeue never frees a slot
  // in the same cycle; that keeps yumi independent of out_ready_i.
  assign full       = (cnt_q == 2'(red_queue_els_gp));
  assign accept     = aresetn & en_i & (&in_v_i) & ~full;
  assign in_yumi_o  = {group_p{accept}};
  assign out_v_o    = (cnt_q != 2'd0);
  assign deq        = out_v_o & out_ready_i;
  assign out_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ deq;
    wr_ptr_d = wr_ptr_q ^ accept;
    cnt_d    = cnt_q + 2'(accept) - 2'(deq);
    count_d  = clear_i ? '0 : count_q + data_width_p'(deq);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
    end
  end

  // Queue storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= reduce_f(in_data_i, red_op_e'(op_i));
    end
  end

endmodule

// File: rtl/zynq_reduce_engine.sv
// Accelerator core: reduces groups of PS->PL FIFO heads into PL->PS results
// and exposes per-output delivery counters and the last AXI-Lite write address.
module zynq_reduce_engine
  import zynq_reduce_pkg::*;
#(
  parameter int  data_width_p = 32,
  parameter int  addr_width_p = 6,
  parameter int  num_in_p     = 4,
  parameter int  group_p      = 2,
  localparam int num_out_p    = num_in_p / group_p
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [num_in_p*data_width_p-1:0]  in_data_i,
  input  logic [num_in_p-1:0]               in_v_i,
  output logic [num_in_p-1:0]               in_yumi_o,
  output logic [num_out_p*data_width_p-1:0] out_data_o,
  output logic [num_out_p-1:0]              out_v_o,
  input  logic [num_out_p-1:0]              out_ready_i,
  input  logic [1:0]                        op_i,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  logic [addr_width_p-1:0]           awaddr_i,
  input  logic                              awvalid_i,
  input  logic                              awready_i,
  output logic [num_out_p*data_width_p-1:0] count_o,
  output logic [addr_width_p-1:0]           last_addr_o
);

  logic [addr_width_p-1:0] last_addr_q, last_addr_d;

  for (genvar g = 0; g < num_out_p; g++) begin : g_lane
    zynq_reduce_lane #(
      .data_width_p(data_width_p),
      .group_p     (group_p)
    ) u_lane (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_data_i  (in_data_i[g*group_p*data_width_p +: group_p*data_width_p]),
      .in_v_i     (in_v_i[g*group_p +: group_p]),
      .in_yumi_o  (in_yumi_o[g*group_p +: group_p]),
      .op_i       (op_i),
      .en_i       (en_i),
      .clear_i    (clear_i),
      .out_data_o (out_data_o[g*data_width_p +: data_width_p]),
      .out_v_o    (out_v_o[g]),
      .out_ready_i(out_ready_i[g]),
      .count_o    (count_o[g*data_width_p +: data_width_p])
    );
  end

  always_comb begin
    last_addr_d = last_addr_q;
    if (awvalid_i && awready_i) begin
      last_addr_d = awaddr_i;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_addr_q <= '0;
    end else begin
      last_addr_q <= last_addr_d;
    end
  end

  assign last_addr_o = last_addr_q;

endmodule

// File: tb/tb_zynq_reduce_engine.sv
// Bench for zynq_reduce_engine: a 32-bit 4-in/2-group instance and a 4-bit
// pass-through instance, both checked against a queue-based reference model.
module tb_zynq_reduce_engine;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [1:0]   op;
  logic         en, clr;
  logic [5:0]   awaddr;
  logic         awvalid, awready;

  logic [127:0] in_data0;
  logic [3:0]   in_v0, yumi0;
  logic [63:0]  out_data0, count0;
  logic [1:0]   out_v0, ready0;
  logic [5:0]   last0;

  logic [7:0]   in_data1, out_data1, count1;
  logic [1:0]   in_v1, yumi1, out_v1, ready1;
  logic [5:0]   last1;

  logic [31:0]  mq [4][$];
  logic [31:0]  mcnt [4];
  logic [5:0]   mladdr;
  int           tests = 0;
  int           fails = 0;

  always #5 aclk = ~aclk;

  zynq_reduce_engine u0 (
    .aclk(aclk), .aresetn(aresetn),
    .in_data_i(in_data0), .in_v_i(in_v0), .in_yumi_o(yumi0),
    .out_data_o(out_data0), .out_v_o(out_v0), .out_ready_i(ready0),
    .op_i(op), .en_i(en), .clear_i(clr),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_i(awready),
    .count_o(count0), .last_addr_o(last0)
  );

  zynq_reduce_engine #(.data_width_p(4), .addr_width_p(6), .num_in_p(2), .group_p(1)) u1 (
    .aclk(aclk), .aresetn(aresetn),
    .in_data_i(in_data1), .in_v_i(in_v1), .in_yumi_o(yumi1),
    .out_data_o(out_data1), .out_v_o(out_v1), .out_ready_i(ready1),
    .op_i(op), .en_i(en), .clear_i(clr),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_i(awready),
    .count_o(count1), .last_addr_o(last1)
  );

  function automatic logic [31:0] ref_reduce(input logic [31:0] a, input logic [31:0] b,
                                             input int n, input int w, input logic [1:0] o);
    longint m;
    m = (longint'(1) << w) - 1;
    if (n == 1) return a;
    case (o)
      2'd0:    return 32'((longint'(a) + longint'(b)) & m);
      2'd1:    return a ^ b;
      2'd2:    return (a > b) ? a : b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check all outputs against the model, advance the model, clock.
  task automatic cycle();
    logic [31:0] a, b, obs_data, obs_cnt, mask;
    logic [1:0]  obs_y, exp_y;
    logic        obs_v, allv, rdy;
    bit          acc, deq;
    int          n, w;
    #1;
    for (int l = 0; l < 4; l++) begin
      if (l < 2) begin
        n = 2; w = 32; mask = 32'hFFFF_FFFF;
        a = in_data0[(2*l)*32 +: 32];
        b = in_data0[(2*l+1)*32 +: 32];
        allv = in_v0[2*l] & in_v0[2*l+1];
        obs_y = yumi0[2*l +: 2];
        obs_v = out_v0[l];
        obs_data = out_data0[l*32 +: 32];
        obs_cnt = count0[l*32 +: 32];
        rdy = ready0[l];
      end else begin
        n = 1; w = 4; mask = 32'hF;
        a = {28'd0, in_data1[(l-2)*4 +: 4]};
        b = 32'd0;
        allv = in_v1[l-2];
        obs_y = {1'b0, yumi1[l-2]};
        obs_v = out_v1[l-2];
        obs_data = {28'd0, out_data1[(l-2)*4 +: 4]};
        obs_cnt = {28'd0, count1[(l-2)*4 +: 4]};
        rdy = ready1[l-2];
      end
      acc = aresetn && en && allv && (mq[l].size() < 2);
      deq = aresetn && (mq[l].size() > 0) && rdy;
      exp_y = acc ? ((n == 2) ? 2'b11 : 2'b01) : 2'b00;
      check($sformatf("yumi_l%0d", l), {30'd0, obs_y}, {30'd0, exp_y});
      check($sformatf("out_v_l%0d", l), {31'd0, obs_v}, {31'd0, mq[l].size() > 0});
      if (mq[l].size() > 0) check($sformatf("out_data_l%0d", l), obs_data, mq[l][0]);
      check($sformatf("count_l%0d", l), obs_cnt, mcnt[l]);
      if (aresetn) begin
        if (deq) void'(mq[l].pop_front());
        if (acc) mq[l].push_back(ref_reduce(a, b, n, w, op));
        if (clr) mcnt[l] = 32'd0;
        else if (deq) mcnt[l] = (mcnt[l] + 32'd1) & mask;
      end
    end
    check("last_addr0", {26'd0, last0}, {26'd0, mladdr});
    check("last_addr1", {26'd0, last1}, {26'd0, mladdr});
    if (aresetn && awvalid && awready) mladdr = awaddr;
    @(posedge aclk);
    #1;
  endtask

  task automatic enter_reset();
    aresetn = 1'b0;
    #1;
    for (int l = 0; l < 4; l++) begin
      mq[l].delete();
      mcnt[l] = 32'd0;
    end
    mladdr = 6'd0;
    check("rst_out_v0", {30'd0, out_v0}, 32'd0);
    check("rst_out_v1", {30'd0, out_v1}, 32'd0);
    check("rst_count0_lo", count0[31:0], 32'd0);
    check("rst_count0_hi", count0[63:32], 32'd0);
    check("rst_count1", {24'd0, count1}, 32'd0);
    check("rst_last0", {26'd0, last0}, 32'd0);
    check("rst_yumi0", {28'd0, yumi0}, 32'd0);
  endtask

  initial begin
    for (int l = 0; l < 4; l++) mcnt[l] = 32'd0;
    mladdr = 6'd0;
    op = 2'd0; en = 1'b1; clr = 1'b0;
    awaddr = 6'd0; awvalid = 1'b0; awready = 1'b0;
    in_data0 = '0; in_v0 = 4'b0000; ready0 = 2'b11;
    in_data1 = '0; in_v1 = 2'b00; ready1 = 2'b11;
    enter_reset();
    cycle();
    cycle();
    aresetn = 1'b1;
    cycle();

    // Basic add on lane 0.
    in_data0[31:0] = 32'd5; in_data0[63:32] = 32'd7; in_v0 = 4'b0011;
    cycle();
    in_v0 = 4'b0000;
    cycle();
    check("add_count0", count0[31:0], 32'd1);
    cycle();

    // Wrap and all operators on lane 1.
    in_data0[95:64] = 32'hFFFF_FFFF; in_data0[127:96] = 32'd2;
    for (int o = 0; o < 4; o++) begin
      op = 2'(o);
      in_v0 = 4'b1100;
      cycle();
      in_v0 = 4'b0000;
      op = 2'(3 - o);
      cycle();
    end
    op = 2'd0;

    // Backpressure on lane 0.
    ready0 = 2'b10;
    in_v0 = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_data0[31:0] = 32'(i + 1); in_data0[63:32] = 32'(10 * i);
      end
      cycle();
    end
    ready0 = 2'b11;
    cycle();
    cycle();
    in_v0 = 4'b0000;
    for (int i = 0; i < 3; i++) cycle();

    // Partial group valid, then disabled drain.
    in_v0 = 4'b0001;
    for (int i = 0; i < 10; i++) cycle();
    ready0 = 2'b10; in_v0 = 4'b0011; in_data0[31:0] = 32'd40; in_data0[63:32] = 32'd2;
    cycle();
    en = 1'b0; ready0 = 2'b11;
    for (int i = 0; i < 3; i++) cycle();
    en = 1'b1; in_v0 = 4'b0000;

    // Clear coinciding with a dequeue.
    in_v0 = 4'b0011;
    cycle();
    in_v0 = 4'b0000; clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();
    check("clear_count0", count0[31:0], 32'd0);

    // AW handshake capture.
    awaddr = 6'h14; awvalid = 1'b1; awready = 1'b1;
    cycle();
    awaddr = 6'h03; awready = 1'b0;
    cycle();
    awvalid = 1'b0;
    cycle();
    check("last_addr_hold", {26'd0, last0}, 32'h14);

    // Narrow counters wrap past 2^4.
    in_v1 = 2'b11;
    for (int i = 0; i < 20; i++) begin
      in_data1 = 8'($urandom);
      cycle();
    end
    in_v1 = 2'b00;
    cycle();
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_data0 = {$urandom, $urandom_range(0, 15), $urandom, 32'($urandom_range(0, 15))};
      in_v0 = 4'($urandom | $urandom);
      in_data1 = 8'($urandom);
      in_v1 = 2'($urandom | $urandom);
      ready0 = 2'($urandom); ready1 = 2'($urandom);
      op = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 19) == 0);
      awaddr = 6'($urandom); awvalid = 1'($urandom); awready = 1'($urandom);
      cycle();
    end
    clr = 1'b0; en = 1'b1; awvalid = 1'b0;

    // Reset with results queued.
    ready0 = 2'b00; ready1 = 2'b00; in_v0 = 4'b1111; in_v1 = 2'b11;
    for (int i = 0; i < 3; i++) cycle();
    enter_reset();
    cycle();
    aresetn = 1'b1;
    in_v0 = 4'b0000; in_v1 = 2'b00; ready0 = 2'b11; ready1 = 2'b11;
    for (int i = 0; i < 3; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
